// File: rtl/alu_rs_if.sv
// Dispatch / CDB / issue bundle for the integer ALU reservation station.
// master = dispatch/CDB/ALU side, slave = the station itself.
interface alu_rs_if #(
  parameter int unsigned TAG_W       = 6,
  parameter int unsigned NUM_ENTRIES = 8
);
  localparam int unsigned CNT_W = $clog2(NUM_ENTRIES) + 1;

  logic             disp_valid;
  logic [4:0]       disp_func;
  logic [63:0]      disp_opa_value;
  logic [TAG_W-1:0] disp_opa_tag;
  logic             disp_opa_ready;
  logic [63:0]      disp_opb_value;
  logic [TAG_W-1:0] disp_opb_tag;
  logic             disp_opb_ready;
  logic [TAG_W-1:0] disp_dest_tag;
  logic             full;
  logic [CNT_W-1:0] free_count;

  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [63:0]      cdb_value;

  logic             issue_valid;
  logic             issue_ready;
  logic [63:0]      issue_opa;
  logic [63:0]      issue_opb;
  logic [4:0]       issue_func;
  logic [TAG_W-1:0] issue_dest_tag;

  modport master (
    output disp_valid, disp_func, disp_opa_value, disp_opa_tag, disp_opa_ready,
           disp_opb_value, disp_opb_tag, disp_opb_ready, disp_dest_tag,
           cdb_valid, cdb_tag, cdb_value, issue_ready,
    input  full, free_count, issue_valid, issue_opa, issue_opb, issue_func,
           issue_dest_tag
  );

  modport slave (
    input  disp_valid, disp_func, disp_opa_value, disp_opa_tag, disp_opa_ready,
           disp_opb_value, disp_opb_tag, disp_opb_ready, disp_dest_tag,
           cdb_valid, cdb_tag, cdb_value, issue_ready,
    output full, free_count, issue_valid, issue_opa, issue_opb, issue_func,
           issue_dest_tag
  );
endinterface

// File: rtl/alu_rs.sv
// Integer ALU reservation station: buffers dispatched ops, wakes operands from the CDB,
// issues the lowest-index ready entry. Optional macro: ALU_RS_DISPATCH_BYPASS_EN.
module alu_rs #(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned TAG_W       = 6
) (
  input  logic    clock,
  input  logic    reset,
  input  logic    flush,
  alu_rs_if.slave rs
);
  localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic [NUM_ENTRIES-1:0] r_valid;
  logic [NUM_ENTRIES-1:0] r_a_rdy;
  logic [NUM_ENTRIES-1:0] r_b_rdy;
  logic [4:0]             r_func  [NUM_ENTRIES];
  logic [TAG_W-1:0]       r_dest  [NUM_ENTRIES];
  logic [TAG_W-1:0]       r_a_tag [NUM_ENTRIES];
  logic [TAG_W-1:0]       r_b_tag [NUM_ENTRIES];
  logic [63:0]            r_a_val [NUM_ENTRIES];
  logic [63:0]            r_b_val [NUM_ENTRIES];

  logic [CNT_W-1:0]       w_occ;
  logic                   w_full;
  logic [IDX_W-1:0]       w_free_idx;
  logic                   w_free_found;
  logic [NUM_ENTRIES-1:0] w_ready_vec;
  logic [IDX_W-1:0]       w_sel_idx;
  logic                   w_sel_found;
  logic                   w_disp_fire;
  logic                   w_issue_fire;
  logic                   w_a_byp;
  logic                   w_b_byp;

  assign w_ready_vec = r_valid & r_a_rdy & r_b_rdy;

  always_comb begin
    w_occ        = '0;
    w_free_idx   = '0;
    w_free_found = 1'b0;
    w_sel_idx    = '0;
    w_sel_found  = 1'b0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      w_occ = w_occ + CNT_W'(r_valid[i]);
      if (!r_valid[i] && !w_free_found) begin
        w_free_idx   = IDX_W'(i);
        w_free_found = 1'b1;
      end
      if (w_ready_vec[i] && !w_sel_found) begin
        w_sel_idx   = IDX_W'(i);
        w_sel_found = 1'b1;
      end
    end
  end

  assign w_full        = (w_occ == CNT_W'(NUM_ENTRIES));
  assign rs.full       = w_full;
  assign rs.free_count = CNT_W'(NUM_ENTRIES) - w_occ;

  // Issue side decodes registered state only; no disp_*/cdb_* path reaches it.
  assign rs.issue_valid    = w_sel_found;
  assign rs.issue_opa      = w_sel_found ? r_a_val[w_sel_idx] : '0;
  assign rs.issue_opb      = w_sel_found ? r_b_val[w_sel_idx] : '0;
  assign rs.issue_func     = w_sel_found ? r_func[w_sel_idx]  : '0;
  assign rs.issue_dest_tag = w_sel_found ? r_dest[w_sel_idx]  : '0;

  assign w_disp_fire  = rs.disp_valid && !w_full;
  assign w_issue_fire = w_sel_found && rs.issue_ready;

`ifdef ALU_RS_DISPATCH_BYPASS_EN
  assign w_a_byp = !rs.disp_opa_ready && rs.cdb_valid && (rs.cdb_tag == rs.disp_opa_tag);
  assign w_b_byp = !rs.disp_opb_ready && rs.cdb_valid && (rs.cdb_tag == rs.disp_opb_tag);
`else
  assign w_a_byp = 1'b0;
  assign w_b_byp = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      r_a_rdy <= '0;
      r_b_rdy <= '0;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        r_func[i]  <= '0;
        r_dest[i]  <= '0;
        r_a_tag[i] <= '0;
        r_b_tag[i] <= '0;
        r_a_val[i] <= '0;
        r_b_val[i] <= '0;
      end
    end else if (flush) begin
      r_valid <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        if (r_valid[i] && rs.cdb_valid) begin
          if (!r_a_rdy[i] && (r_a_tag[i] == rs.cdb_tag)) begin
            r_a_rdy[i] <= 1'b1;
            r_a_val[i] <= rs.cdb_value;
          end
          if (!r_b_rdy[i] && (r_b_tag[i] == rs.cdb_tag)) begin
            r_b_rdy[i] <= 1'b1;
            r_b_val[i] <= rs.cdb_value;
          end
        end
      end
      if (w_issue_fire) r_valid[w_sel_idx] <= 1'b0;
      // Dispatch slot is currently invalid, so it never collides with the issued or woken entries.
      if (w_disp_fire) begin
        r_valid[w_free_idx] <= 1'b1;
        r_func[w_free_idx]  <= rs.disp_func;
        r_dest[w_free_idx]  <= rs.disp_dest_tag;
        r_a_rdy[w_free_idx] <= rs.disp_opa_ready || w_a_byp;
        r_a_tag[w_free_idx] <= rs.disp_opa_tag;
        r_a_val[w_free_idx] <= w_a_byp ? rs.cdb_value : rs.disp_opa_value;
        r_b_rdy[w_free_idx] <= rs.disp_opb_ready || w_b_byp;
        r_b_tag[w_free_idx] <= rs.disp_opb_tag;
        r_b_val[w_free_idx] <= w_b_byp ? rs.cdb_value : rs.disp_opb_value;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (reset && rs.disp_valid)
      assert (!w_full) else $warning("alu_rs: dispatch while full dropped");
  end
`endif
endmodule
